ahb_slave_if: RTL and testbench
===============================

Name: ahb_slave_if

Overview:
- AHB-Lite slave front end of the AHB-to-APB bridge. Sits directly downstream of the AHB master and upstream of the APB controller FSM.
- Qualifies and pipelines AHB address/data phases, decodes the target peripheral, and issues one request at a time over a valid/ready handshake.
- Returns the read data or response to the master with wait states and the AHB two-cycle ERROR response.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- NUM_SLV, 3, number of APB peripherals
- BASE_ADDR, 32'h8000_0000, bridge base address
- REGION_LOG2, 10, log2 bytes per peripheral region (1 KB)

Ports:
- Hclk  in  1  AHB clock
- Hresetn  in  1  async active-low reset
- Hreadyin  in  1  bus HREADY
- Htrans  in  2  transfer type
- Hwrite  in  1  1=write
- Hsize  in  3  transfer size
- Haddr  in  ADDR_W  address
- Hwdata  in  DATA_W  write data
- Hreadyout  out  1  slave ready
- Hresp  out  2  00 OKAY, 01 ERROR
- Hrdata  out  DATA_W  read data
- req_valid  out  1  request to APB FSM
- req_ready  in  1  APB FSM accepts request
- req_write  out  1  request direction
- req_addr  out  ADDR_W  latched address
- req_wdata  out  DATA_W  latched write data
- req_sel  out  NUM_SLV  one-hot peripheral select
- rsp_valid  in  1  APB transfer complete
- rsp_rdata  in  DATA_W  APB read data
- rsp_err  in  1  PSLVERR

Behaviour:
- Clock Hclk; reset Hresetn, asynchronous, active-low.
- Reset values:
  - Hreadyout=1, Hresp=00, Hrdata=0.
  - req_valid=0, req_write=0, req_addr=0, req_wdata=0, req_sel=0.
  - State IDLE.
- Valid transfer: Hreadyin & Hreadyout & Htrans∈{NONSEQ 10, SEQ 11}.
  - IDLE (00) and BUSY (01) transfers get zero-wait OKAY.
  - Bursts are treated beat by beat.
- Decode: in range iff BASE_ADDR <= Haddr < BASE_ADDR + NUM_SLV<<REGION_LOG2, and Hsize<=2.
  - req_sel = one-hot((Haddr-BASE_ADDR)>>REGION_LOG2).
- States:
  - IDLE:
    - Hreadyout=1.
    - Valid in-range transfer → latch Haddr/Hwrite/req_sel, go to DPHASE.
    - Valid out-of-range transfer → ERR1.
  - DPHASE (1 cycle): Hreadyout=0; capture Hwdata into req_wdata on writes; → REQ.
  - REQ: req_valid=1, fields held stable; req_ready → WAIT.
  - WAIT:
    - Hreadyout=0.
    - rsp_valid & !rsp_err → latch rsp_rdata into Hrdata on reads, → DONE.
    - rsp_valid & rsp_err → ERR1.
  - DONE: Hreadyout=1, Hresp=00. Acts as an address phase: a new valid transfer is accepted exactly as in IDLE; otherwise → IDLE.
  - ERR1: Hreadyout=0, Hresp=01; → ERR2.
  - ERR2: Hreadyout=1, Hresp=01. Acts as an address phase like DONE; otherwise → IDLE.
- Latency:
  - Address phase at cycle A; req_valid at A+2.
  - With req_ready=1 at A+2 and rsp_valid=1 at A+3, Hreadyout=1 (DONE) at A+4.
  - Minimum 3 wait states.
- rsp_valid outside WAIT is ignored.
- Hreadyin low: no transfer accepted; state holds.
- Hrdata holds its last value between reads.
- Reset mid-operation: pending request dropped, everything returns to reset values. The APB FSM shares Hresetn.

Optional Feature:
- Macro AHB_SLV_WRITE_BUF_EN.
- Defined (posted writes):
  - An in-range write completes with Hreadyout=1 in DPHASE (zero-wait) when the buffer is free.
  - The buffered write is then issued through REQ/WAIT in the background.
  - A transfer arriving while the buffer is busy is held with Hreadyout=0 in its data phase until the buffered write's rsp_valid.
  - rsp_err on a posted write sets the extra output wr_err_sticky (1 bit, reset 0). It is cleared only by reset. No AHB ERROR is returned for that write.
- Undefined: all writes are non-posted as above, and port wr_err_sticky does not exist.

Decomposition:
- Package ahb_apb_pkg holds:
  - HTRANS codes (IDLE, BUSY, NONSEQ, SEQ).
  - HRESP codes (OKAY, ERROR).
  - HSIZE codes.
  - The state encoding.
- Sub-module ahb_addr_decode: combinational range check and one-hot req_sel generation. It is reused by the APB controller.

Test Plan:
- Write NONSEQ Haddr=0x8000_0001, Hwdata=0x0000_00A3, req_ready=1, rsp_valid at A+3 → req_sel=001, req_wdata=0xA3, Hreadyout low A+1..A+3, OKAY at A+4.
- Read Haddr=0x8000_04A2, rsp_rdata=0x1234_5678 → req_sel=010, Hrdata=0x1234_5678 at DONE, Hresp=00.
- Read Haddr=0x8000_0C00 (out of range) → no req_valid; Hresp=01 with Hreadyout 0 then 1.
- rsp_err=1 on a write to 0x8000_0800 → req_sel=100, two-cycle ERROR response.
- Back-to-back: new NONSEQ presented during DONE is accepted; req_ready held low 5 cycles keeps req_valid and fields stable; Htrans=BUSY → no request.
- Hresetn pulsed low while in WAIT → outputs at reset values immediately; a rsp_valid arriving after reset is ignored.
- With AHB_SLV_WRITE_BUF_EN: write then read → write OKAY at A+1; read held until the write's rsp_valid; rsp_err on the write → wr_err_sticky=1.

Source files
------------

// File: rtl/ahb_apb_pkg.sv
// Shared codes for the AHB-to-APB bridge: HTRANS/HRESP/HSIZE encodings and the
// AHB slave front-end state encoding.
package ahb_apb_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [1:0] HRESP_OKAY    = 2'b00;
   localparam logic [1:0] HRESP_ERROR   = 2'b01;

   localparam logic [2:0] HSIZE_BYTE    = 3'd0;
   localparam logic [2:0] HSIZE_HALF    = 3'd1;
   localparam logic [2:0] HSIZE_WORD    = 3'd2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DPHASE,
      ST_REQ,
      ST_WAIT,
      ST_DONE,
      ST_ERR1,
      ST_ERR2
   } slv_state_t;

endpackage

// File: rtl/ahb_addr_decode.sv
// Bridge address decoder: range/size check and one-hot peripheral select.
// Purely combinational; shared by the AHB front end and the APB controller.
module ahb_addr_decode
   import ahb_apb_pkg::*;
#(
   parameter int                ADDR_W      = 32,
   parameter int                NUM_SLV     = 3,
   parameter int                REGION_LOG2 = 10,
   parameter logic [ADDR_W-1:0] BASE_ADDR   = 'h8000_0000
) (
   input  logic [ADDR_W-1:0]  addr,
   input  logic [2:0]         size,
   output logic               hit,
   output logic [NUM_SLV-1:0] sel
);

   localparam int              IDX_W = ADDR_W - REGION_LOG2;
   localparam logic [ADDR_W:0] SPAN  = (ADDR_W+1)'(NUM_SLV) << REGION_LOG2;

   logic [ADDR_W-1:0] off;

   always_comb begin
      off = addr - BASE_ADDR;
      // The offset is widened by one bit so a span ending at the top of the map cannot wrap.
      hit = (addr >= BASE_ADDR) && ({1'b0, off} < SPAN) && (size <= HSIZE_WORD);
      for (int i = 0; i < NUM_SLV; i++)
         sel[i] = hit && (off[ADDR_W-1:REGION_LOG2] == IDX_W'(i));
   end

endmodule

// File: rtl/ahb_slave_if.sv
// AHB-Lite slave front end of the AHB-to-APB bridge: one request at a time to the APB FSM.
// Define AHB_SLV_WRITE_BUF_EN for posted (zero-wait) writes and the wr_err_sticky output.
module ahb_slave_if
   import ahb_apb_pkg::*;
#(
   parameter int                ADDR_W      = 32,
   parameter int                DATA_W      = 32,
   parameter int                NUM_SLV     = 3,
   parameter logic [ADDR_W-1:0] BASE_ADDR   = 'h8000_0000,
   parameter int                REGION_LOG2 = 10
) (
   input  logic               Hclk,
   input  logic               Hresetn,
   input  logic               Hreadyin,
   input  logic [1:0]         Htrans,
   input  logic               Hwrite,
   input  logic [2:0]         Hsize,
   input  logic [ADDR_W-1:0]  Haddr,
   input  logic [DATA_W-1:0]  Hwdata,
   output logic               Hreadyout,
   output logic [1:0]         Hresp,
   output logic [DATA_W-1:0]  Hrdata,
   output logic               req_valid,
   input  logic               req_ready,
   output logic               req_write,
   output logic [ADDR_W-1:0]  req_addr,
   output logic [DATA_W-1:0]  req_wdata,
   output logic [NUM_SLV-1:0] req_sel,
   input  logic               rsp_valid,
   input  logic [DATA_W-1:0]  rsp_rdata,
`ifdef AHB_SLV_WRITE_BUF_EN
   output logic               wr_err_sticky,
`endif
   input  logic               rsp_err
);

   slv_state_t         state_q, state_d;
   logic [ADDR_W-1:0]  req_addr_q, req_addr_d;
   logic               req_write_q, req_write_d;
   logic [DATA_W-1:0]  req_wdata_q, req_wdata_d;
   logic [NUM_SLV-1:0] req_sel_q, req_sel_d;
   logic [DATA_W-1:0]  hrdata_q, hrdata_d;
   logic [NUM_SLV-1:0] dec_sel;
   logic               dec_hit, xfer, take_bus, bg_wr;

   ahb_addr_decode #(
      .ADDR_W(ADDR_W), .NUM_SLV(NUM_SLV), .REGION_LOG2(REGION_LOG2), .BASE_ADDR(BASE_ADDR)
   ) u_dec (
      .addr(Haddr), .size(Hsize), .hit(dec_hit), .sel(dec_sel)
   );

`ifdef AHB_SLV_WRITE_BUF_EN
   logic               pend_q, pend_d, pend_hit_q, pend_hit_d;
   logic               pend_write_q, pend_write_d, sticky_q, sticky_d, take_pend;
   logic [ADDR_W-1:0]  pend_addr_q, pend_addr_d;
   logic [NUM_SLV-1:0] pend_sel_q, pend_sel_d;

   // In DPHASE/REQ/WAIT a set req_write_q means a posted write draining in the background.
   assign bg_wr         = req_write_q & ~pend_q;
   assign wr_err_sticky = sticky_q;
`else
   assign bg_wr         = 1'b0;
`endif

   always_comb begin
      Hreadyout = 1'b1;
      Hresp     = HRESP_OKAY;
      case (state_q)
         ST_DPHASE, ST_REQ, ST_WAIT: Hreadyout = bg_wr;
         ST_ERR1: begin
            Hreadyout = 1'b0;
            Hresp     = HRESP_ERROR;
         end
         ST_ERR2: Hresp = HRESP_ERROR;
         default: ;
      endcase
   end

   assign xfer = Hreadyin & Hreadyout & ((Htrans == HTRANS_NONSEQ) | (Htrans == HTRANS_SEQ));

   always_comb begin
      state_d     = state_q;
      req_addr_d  = req_addr_q;
      req_write_d = req_write_q;
      req_wdata_d = req_wdata_q;
      req_sel_d   = req_sel_q;
      hrdata_d    = hrdata_q;
      take_bus    = 1'b0;
`ifdef AHB_SLV_WRITE_BUF_EN
      pend_d       = pend_q;
      pend_hit_d   = pend_hit_q;
      pend_write_d = pend_write_q;
      pend_addr_d  = pend_addr_q;
      pend_sel_d   = pend_sel_q;
      sticky_d     = sticky_q;
      take_pend    = 1'b0;
`endif
      case (state_q)
         ST_IDLE, ST_DONE, ST_ERR2: begin
            state_d  = ST_IDLE;
            take_bus = xfer;
         end
         ST_DPHASE: begin
            if (req_write_q) req_wdata_d = Hwdata;
            state_d = ST_REQ;
         end
         ST_REQ: if (req_ready) state_d = ST_WAIT;
         ST_WAIT: if (rsp_valid) begin
`ifdef AHB_SLV_WRITE_BUF_EN
            if (req_write_q) begin
               sticky_d  = sticky_q | rsp_err;
               state_d   = ST_IDLE;
               take_pend = pend_q;
               take_bus  = ~pend_q & xfer;
            end else
`endif
            if (rsp_err) state_d = ST_ERR1;
            else begin
               if (!req_write_q) hrdata_d = rsp_rdata;
               state_d = ST_DONE;
            end
         end
         ST_ERR1: state_d = ST_ERR2;
         default: state_d = ST_IDLE;
      endcase
`ifdef AHB_SLV_WRITE_BUF_EN
      // Transfer arriving behind a posted write is parked; its data phase stalls until the drain.
      if (xfer && !take_bus) begin
         pend_d       = 1'b1;
         pend_hit_d   = dec_hit;
         pend_write_d = Hwrite;
         pend_addr_d  = Haddr;
         pend_sel_d   = dec_sel;
      end
      if (take_pend) begin
         pend_d  = 1'b0;
         state_d = pend_hit_q ? ST_DPHASE : ST_ERR1;
         if (pend_hit_q) begin
            req_addr_d  = pend_addr_q;
            req_write_d = pend_write_q;
            req_sel_d   = pend_sel_q;
         end
      end
`endif
      if (take_bus) begin
         state_d = dec_hit ? ST_DPHASE : ST_ERR1;
         if (dec_hit) begin
            req_addr_d  = Haddr;
            req_write_d = Hwrite;
            req_sel_d   = dec_sel;
         end
      end
   end

   always_ff @(posedge Hclk or negedge Hresetn) begin
      if (!Hresetn) begin
         state_q     <= ST_IDLE;
         req_addr_q  <= '0;
         req_write_q <= 1'b0;
         req_wdata_q <= '0;
         req_sel_q   <= '0;
         hrdata_q    <= '0;
      end else begin
         state_q     <= state_d;
         req_addr_q  <= req_addr_d;
         req_write_q <= req_write_d;
         req_wdata_q <= req_wdata_d;
         req_sel_q   <= req_sel_d;
         hrdata_q    <= hrdata_d;
      end
   end

`ifdef AHB_SLV_WRITE_BUF_EN
   always_ff @(posedge Hclk or negedge Hresetn) begin
      if (!Hresetn) begin
         pend_q       <= 1'b0;
         pend_hit_q   <= 1'b0;
         pend_write_q <= 1'b0;
         pend_addr_q  <= '0;
         pend_sel_q   <= '0;
         sticky_q     <= 1'b0;
      end else begin
         pend_q       <= pend_d;
         pend_hit_q   <= pend_hit_d;
         pend_write_q <= pend_write_d;
         pend_addr_q  <= pend_addr_d;
         pend_sel_q   <= pend_sel_d;
         sticky_q     <= sticky_d;
      end
   end
`endif

   assign req_valid = (state_q == ST_REQ);
   assign req_write = req_write_q;
   assign req_addr  = req_addr_q;
   assign req_wdata = req_wdata_q;
   assign req_sel   = req_sel_q;
   assign Hrdata    = hrdata_q;

endmodule

// File: tb/tb_ahb_slave_if.sv
// Self-checking bench for ahb_slave_if: directed plan items plus randomized transfers
// checked cycle by cycle against a transaction-level expectation model.
module tb_ahb_slave_if;

   localparam logic [31:0] BASE = 32'h8000_0000;
`ifdef AHB_SLV_WRITE_BUF_EN
   localparam bit POSTED = 1'b1;
`else
   localparam bit POSTED = 1'b0;
`endif

   logic        Hclk = 1'b0, Hresetn = 1'b1, Hreadyin = 1'b1, Hwrite = 1'b0;
   logic [1:0]  Htrans = 2'b00;
   logic [2:0]  Hsize = 3'd2;
   logic [31:0] Haddr = '0, Hwdata = '0, rsp_rdata = '0;
   logic        req_ready = 1'b0, rsp_valid = 1'b0, rsp_err = 1'b0;
   logic        Hreadyout, req_valid, req_write;
   logic [1:0]  Hresp;
   logic [31:0] Hrdata, req_addr, req_wdata;
   logic [2:0]  req_sel;
`ifdef AHB_SLV_WRITE_BUF_EN
   logic        wr_err_sticky;
`endif

   int          n_cmp = 0, n_bad = 0;
   logic [31:0] exp_rdata = '0;
   bit          exp_sticky = 1'b0;

   ahb_slave_if dut (
      .Hclk(Hclk), .Hresetn(Hresetn), .Hreadyin(Hreadyin), .Htrans(Htrans), .Hwrite(Hwrite),
      .Hsize(Hsize), .Haddr(Haddr), .Hwdata(Hwdata), .Hreadyout(Hreadyout), .Hresp(Hresp),
      .Hrdata(Hrdata), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_sel(req_sel), .rsp_valid(rsp_valid),
      .rsp_rdata(rsp_rdata),
`ifdef AHB_SLV_WRITE_BUF_EN
      .wr_err_sticky(wr_err_sticky),
`endif
      .rsp_err(rsp_err)
   );

   always #5 Hclk = ~Hclk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   // Reference decode: 3 regions of 1 KB from BASE, word-or-smaller only.
   function automatic bit m_hit(input logic [31:0] a, input logic [2:0] sz);
      return (a >= BASE) && (a < BASE + 32'd3072) && (sz <= 3'd2);
   endfunction
   function automatic logic [2:0] m_sel(input logic [31:0] a);
      return 3'(1 << ((a - BASE) / 1024));
   endfunction

   task automatic tick;
      @(posedge Hclk);
      #1;
   endtask

   task automatic test_reset;
      #2 Hresetn = 1'b0;
      #1;
      n_cmp++;
      if ({Hreadyout, Hresp, Hrdata, req_valid, req_write, req_addr, req_wdata, req_sel} !== {1'b1, 2'b00, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000}) begin
         n_bad++;
         $display("FAIL reset: rdy=%b resp=%b rdata=%h vld=%b wr=%b addr=%h wdata=%h sel=%b, want 1/00/0/0/0/0/0/000",
                  Hreadyout, Hresp, Hrdata, req_valid, req_write, req_addr, req_wdata, req_sel);
      end
`ifdef AHB_SLV_WRITE_BUF_EN
      n_cmp++;
      if (wr_err_sticky !== 1'b0) begin n_bad++; $display("FAIL reset sticky: got %b want 0", wr_err_sticky); end
`endif
      tick;
      Hresetn = 1'b1;
      tick;
   endtask

   // One complete transfer starting in an address-phase cycle; returns in its last
   // completing cycle so the next call lands back-to-back.
   task automatic do_xfer(input string nm, input bit wr, input logic [31:0] a, input logic [2:0] sz,
                          input logic [31:0] wd, input logic [31:0] rd, input bit perr,
                          input int rdy_dly, input int rsp_dly);
      bit hit, pst;
      logic [2:0] sel;
      hit = m_hit(a, sz);
      pst = POSTED && wr && hit;
      sel = m_sel(a);
      n_cmp++;
      if (Hreadyout !== 1'b1) begin n_bad++; $display("FAIL %s addr-phase: Hreadyout=%b want 1", nm, Hreadyout); end
      Htrans = 2'b10; Hwrite = wr; Haddr = a; Hsize = sz; Hwdata = $urandom;
      tick;
      Htrans = 2'b00; Haddr = $urandom; Hwrite = 1'($urandom); Hwdata = wd;
      if (!hit) begin
         n_cmp++;
         if ({Hreadyout, Hresp, req_valid} !== 4'b0_01_0) begin
            n_bad++; $display("FAIL %s err1: rdy/resp/vld=%b%b%b want 0 01 0", nm, Hreadyout, Hresp, req_valid);
         end
         tick;
         n_cmp++;
         if ({Hreadyout, Hresp, req_valid} !== 4'b1_01_0) begin
            n_bad++; $display("FAIL %s err2: rdy/resp/vld=%b%b%b want 1 01 0", nm, Hreadyout, Hresp, req_valid);
         end
         return;
      end
      n_cmp++;
      if ({Hreadyout, Hresp, req_valid} !== {pst, 2'b00, 1'b0}) begin
         n_bad++; $display("FAIL %s dphase: rdy/resp/vld=%b%b%b want %b 00 0", nm, Hreadyout, Hresp, req_valid, pst);
      end
      tick;
      Hwdata = $urandom;
      for (int i = 0; i <= rdy_dly; i++) begin
         req_ready = (i == rdy_dly);
         rsp_valid = (i != rdy_dly) && ($urandom_range(0, 1) == 1);
         rsp_err   = 1'($urandom);
         rsp_rdata = $urandom;
         n_cmp++;
         if ({Hreadyout, Hresp, req_valid, req_write, req_addr, req_sel} !== {pst, 2'b00, 1'b1, wr, a, sel}) begin
            n_bad++;
            $display("FAIL %s req: rdy=%b resp=%b vld=%b wr=%b addr=%h sel=%b want %b 00 1 %b %h %b",
                     nm, Hreadyout, Hresp, req_valid, req_write, req_addr, req_sel, pst, wr, a, sel);
         end
         if (wr) begin
            n_cmp++;
            if (req_wdata !== wd) begin n_bad++; $display("FAIL %s wdata: got %h want %h", nm, req_wdata, wd); end
         end
         tick;
      end
      req_ready = 1'b0;
      for (int i = 0; i <= rsp_dly; i++) begin
         rsp_valid = (i == rsp_dly);
         rsp_err   = perr;
         rsp_rdata = (i == rsp_dly) ? rd : $urandom;
         n_cmp++;
         if ({Hreadyout, Hresp, req_valid} !== {pst, 2'b00, 1'b0}) begin
            n_bad++; $display("FAIL %s wait: rdy/resp/vld=%b%b%b want %b 00 0", nm, Hreadyout, Hresp, req_valid, pst);
         end
         tick;
      end
      rsp_valid = 1'b0; rsp_err = 1'b0; rsp_rdata = $urandom;
      if (pst || !perr) begin
         if (pst) exp_sticky = exp_sticky | perr;
         else if (!wr) exp_rdata = rd;
         n_cmp++;
         if ({Hreadyout, Hresp, req_valid} !== 4'b1_00_0) begin
            n_bad++; $display("FAIL %s done: rdy/resp/vld=%b%b%b want 1 00 0", nm, Hreadyout, Hresp, req_valid);
         end
      end else begin
         n_cmp++;
         if ({Hreadyout, Hresp, req_valid} !== 4'b0_01_0) begin
            n_bad++; $display("FAIL %s perr1: rdy/resp/vld=%b%b%b want 0 01 0", nm, Hreadyout, Hresp, req_valid);
         end
         tick;
         n_cmp++;
         if ({Hreadyout, Hresp, req_valid} !== 4'b1_01_0) begin
            n_bad++; $display("FAIL %s perr2: rdy/resp/vld=%b%b%b want 1 01 0", nm, Hreadyout, Hresp, req_valid);
         end
      end
      n_cmp++;
      if (Hrdata !== exp_rdata) begin n_bad++; $display("FAIL %s Hrdata: got %h want %h", nm, Hrdata, exp_rdata); end
`ifdef AHB_SLV_WRITE_BUF_EN
      n_cmp++;
      if (wr_err_sticky !== exp_sticky) begin n_bad++; $display("FAIL %s sticky: got %b want %b", nm, wr_err_sticky, exp_sticky); end
`endif
   endtask

   task automatic test_directed;
      do_xfer("wr_slv0",   1'b1, 32'h8000_0001, 3'd2, 32'h0000_00A3, 32'h0,         1'b0, 0, 0);
      do_xfer("rd_slv1",   1'b0, 32'h8000_04A2, 3'd1, 32'h0,         32'h1234_5678, 1'b0, 0, 0);
      do_xfer("rd_oor",    1'b0, 32'h8000_0C00, 3'd2, 32'h0,         32'h0,         1'b0, 0, 0);
      do_xfer("wr_perr",   1'b1, 32'h8000_0800, 3'd2, 32'hCAFE_F00D, 32'h0,         1'b1, 0, 0);
      do_xfer("rd_perr",   1'b0, 32'h8000_0400, 3'd0, 32'h0,         32'hDEAD_BEEF, 1'b1, 1, 2);
      do_xfer("rd_hold5",  1'b0, 32'h8000_0BFF, 3'd0, 32'h0,         32'h0BAD_1DEA, 1'b0, 5, 1);
      do_xfer("wr_hold5",  1'b1, 32'h8000_03FC, 3'd2, 32'h5555_AAAA, 32'h0,         1'b0, 5, 3);
      do_xfer("rd_size3",  1'b0, 32'h8000_0000, 3'd3, 32'h0,         32'h0,         1'b0, 0, 0);
      do_xfer("rd_below",  1'b0, 32'h7FFF_FFFC, 3'd2, 32'h0,         32'h0,         1'b0, 0, 0);
   endtask

   task automatic test_idle_busy;
      Htrans = 2'b01; Hwrite = 1'b0; Haddr = 32'h8000_0010; Hsize = 3'd2;
      tick;
      Htrans = 2'b00;
      for (int i = 0; i < 3; i++) begin
         n_cmp++;
         if ({Hreadyout, Hresp, req_valid} !== 4'b1_00_0) begin
            n_bad++; $display("FAIL busy[%0d]: rdy/resp/vld=%b%b%b want 1 00 0", i, Hreadyout, Hresp, req_valid);
         end
         tick;
      end
      Hreadyin = 1'b0; Htrans = 2'b10; Haddr = 32'h8000_0420;
      for (int i = 0; i < 3; i++) begin
         tick;
         n_cmp++;
         if ({Hreadyout, Hresp, req_valid} !== 4'b1_00_0) begin
            n_bad++; $display("FAIL hreadyin_low[%0d]: rdy/resp/vld=%b%b%b want 1 00 0", i, Hreadyout, Hresp, req_valid);
         end
      end
      Hreadyin = 1'b1; Htrans = 2'b00;
      tick;
   endtask

   task automatic test_random;
      for (int n = 0; n < 40; n++) begin
         logic [31:0] a;
         logic [2:0]  sz;
         int k;
         k = $urandom_range(0, 9);
         if (k < 7)       a = BASE + $urandom_range(0, 3071);
         else if (k == 7) a = BASE + 32'd3072 + $urandom_range(0, 4095);
         else if (k == 8) a = BASE - 32'd1 - $urandom_range(0, 255);
         else             a = $urandom;
         sz = ($urandom_range(0, 7) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
         do_xfer("rand", 1'($urandom_range(0, 1)), a, sz, $urandom, $urandom,
                 $urandom_range(0, 4) == 0, $urandom_range(0, 3), $urandom_range(0, 3));
         if ($urandom_range(0, 2) == 0) begin
            Htrans = 2'b00;
            tick;
         end
      end
      Htrans = 2'b00;
      tick;
   endtask

   task automatic test_reset_mid;
      Htrans = 2'b10; Hwrite = 1'b0; Haddr = 32'h8000_0444; Hsize = 3'd2;
      tick;
      Htrans = 2'b00;
      tick;
      req_ready = 1'b1;
      tick;
      req_ready = 1'b0;
      n_cmp++;
      if ({Hreadyout, req_valid} !== 2'b00) begin
         n_bad++; $display("FAIL mid_wait: rdy/vld=%b%b want 00", Hreadyout, req_valid);
      end
      #2 Hresetn = 1'b0;
      #1;
      exp_rdata = '0;
      exp_sticky = 1'b0;
      n_cmp++;
      if ({Hreadyout, Hresp, Hrdata, req_valid, req_write, req_addr, req_wdata, req_sel} !== {1'b1, 2'b00, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000}) begin
         n_bad++;
         $display("FAIL mid_reset: rdy=%b resp=%b rdata=%h vld=%b wr=%b addr=%h wdata=%h sel=%b, want reset values",
                  Hreadyout, Hresp, Hrdata, req_valid, req_write, req_addr, req_wdata, req_sel);
      end
      tick;
      Hresetn = 1'b1;
      rsp_valid = 1'b1; rsp_rdata = 32'hFEED_FACE;
      tick;
      rsp_valid = 1'b0;
      tick;
      n_cmp++;
      if ({Hreadyout, Hresp, Hrdata, req_valid} !== {1'b1, 2'b00, 32'h0, 1'b0}) begin
         n_bad++; $display("FAIL post_reset_rsp: rdy=%b resp=%b rdata=%h vld=%b want 1 00 0 0", Hreadyout, Hresp, Hrdata, req_valid);
      end
   endtask

`ifdef AHB_SLV_WRITE_BUF_EN
   task automatic test_posted;
      Htrans = 2'b10; Hwrite = 1'b1; Haddr = 32'h8000_0010; Hsize = 3'd2;
      tick;
      n_cmp++;
      if ({Hreadyout, Hresp} !== 3'b1_00) begin n_bad++; $display("FAIL posted_wr_ok: rdy/resp=%b%b want 1 00", Hreadyout, Hresp); end
      Htrans = 2'b10; Hwrite = 1'b0; Haddr = 32'h8000_0404; Hwdata = 32'h7777_0001;
      tick;
      Htrans = 2'b00; Hwdata = $urandom;
      n_cmp++;
      if ({Hreadyout, req_valid, req_write, req_addr, req_wdata} !== {1'b0, 1'b1, 1'b1, 32'h8000_0010, 32'h7777_0001}) begin
         n_bad++; $display("FAIL posted_req: rdy=%b vld=%b wr=%b addr=%h wdata=%h", Hreadyout, req_valid, req_write, req_addr, req_wdata);
      end
      req_ready = 1'b1;
      tick;
      req_ready = 1'b0;
      n_cmp++;
      if (Hreadyout !== 1'b0) begin n_bad++; $display("FAIL posted_hold: Hreadyout=%b want 0", Hreadyout); end
      rsp_valid = 1'b1; rsp_err = 1'b1;
      tick;
      rsp_valid = 1'b0; rsp_err = 1'b0;
      exp_sticky = 1'b1;
      n_cmp++;
      if ({Hreadyout, Hresp, req_valid, wr_err_sticky} !== {1'b0, 2'b00, 1'b0, 1'b1}) begin
         n_bad++; $display("FAIL posted_err: rdy=%b resp=%b vld=%b sticky=%b want 0 00 0 1", Hreadyout, Hresp, req_valid, wr_err_sticky);
      end
      tick;
      n_cmp++;
      if ({req_valid, req_write, req_addr, req_sel} !== {1'b1, 1'b0, 32'h8000_0404, 3'b010}) begin
         n_bad++; $display("FAIL held_rd_req: vld=%b wr=%b addr=%h sel=%b", req_valid, req_write, req_addr, req_sel);
      end
      req_ready = 1'b1;
      tick;
      req_ready = 1'b0; rsp_valid = 1'b1; rsp_rdata = 32'h0A0B_0C0D;
      tick;
      rsp_valid = 1'b0;
      exp_rdata = 32'h0A0B_0C0D;
      n_cmp++;
      if ({Hreadyout, Hresp, Hrdata, wr_err_sticky} !== {1'b1, 2'b00, exp_rdata, 1'b1}) begin
         n_bad++; $display("FAIL held_rd_done: rdy=%b resp=%b rdata=%h sticky=%b", Hreadyout, Hresp, Hrdata, wr_err_sticky);
      end
   endtask
`endif

   initial begin
      test_reset;
      test_directed;
      test_idle_busy;
      test_random;
      test_reset_mid;
`ifdef AHB_SLV_WRITE_BUF_EN
      test_posted;
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
